// File: rtl/qa_buffer_loopback.sv
// ---------------------------------------------------------------------------
// qa_buffer_loopback
//
// Buffered, rate-limited loopback for the QA harness. Words offered on
// in_data/in_nd are queued in a 2**LOG_DEPTH entry circular FIFO and replayed
// in order on out_data/out_nd, with at least GAP idle cycles between
// consecutive output words. There is no backpressure: a word that arrives
// while the FIFO is full (and no read frees a slot that cycle) is dropped.
//
// Parameters:
//   WDTH      - data word width
//   LOG_DEPTH - log2 of the FIFO depth
//   GAP       - minimum idle cycles between out_nd pulses (0..255)
//
// Ports:
//   clk      in   rising-edge clock, the only clock
//   reset    in   synchronous, active-high; clears FIFO, FSM and outputs
//   in_data  in   [WDTH-1:0] input word, sampled when in_nd is high
//   in_nd    in   input word valid
//   out_data out  [WDTH-1:0] registered output word, held while out_nd low
//   out_nd   out  registered output valid, one cycle per word
//   error    out  registered sticky overflow flag
//   fill     out  [LOG_DEPTH:0] registered FIFO occupancy, 0..DEPTH
//
// Build option:
//   QA_LOOPBACK_OVERFLOW_ERR_EN - when defined, a dropped word sets error,
//   which stays high until reset. When undefined, error is tied low. The
//   FIFO itself (including the drop) behaves identically in both builds.
// ---------------------------------------------------------------------------
module qa_buffer_loopback #(
  parameter int WDTH      = 32,
  parameter int LOG_DEPTH = 4,
  parameter int GAP       = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WDTH-1:0]      in_data,
  input  logic                 in_nd,
  output logic [WDTH-1:0]      out_data,
  output logic                 out_nd,
  output logic                 error,
  output logic [LOG_DEPTH:0]   fill
);

  localparam int DEPTH = 2 ** LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] FULL = (LOG_DEPTH + 1)'(DEPTH);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [7:0]             gap_cnt;
  logic [7:0]             gap_cnt_next;

  logic [LOG_DEPTH-1:0]   wr_ptr;
  logic [LOG_DEPTH-1:0]   rd_ptr;
  logic [WDTH-1:0]        mem [DEPTH];

  logic                   do_read;
  logic                   do_write;

  // A read in the same cycle frees the head slot, so a full FIFO can still
  // accept a word when it is also emitting one. The read of the head entry
  // sees the old contents because the memory update is non-blocking.
  assign do_write = in_nd && ((fill != FULL) || do_read);

  // FSM state register, including the inter-word gap counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gap_cnt <= 8'd0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_cnt_next;
    end
  end

  // FSM next state. HOLD lasts exactly GAP cycles after each read, which
  // spaces output pulses GAP+1 cycles apart while data is waiting.
  always_comb begin
    state_next   = state;
    gap_cnt_next = gap_cnt;
    case (state)
      IDLE: begin
        if (do_read && (GAP > 0)) begin
          state_next   = HOLD;
          gap_cnt_next = 8'(GAP - 1);
        end
      end
      HOLD: begin
        if (gap_cnt == 8'd0) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt - 8'd1;
        end
      end
      default: begin
        state_next   = IDLE;
        gap_cnt_next = 8'd0;
      end
    endcase
  end

  // FSM outputs: a read is only issued from IDLE and only with data present.
  always_comb begin
    do_read = 1'b0;
    if ((state == IDLE) && (fill != '0)) begin
      do_read = 1'b1;
    end
  end

  // Pointers, occupancy and the registered output word.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      out_nd   <= 1'b0;
      out_data <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + LOG_DEPTH'(1);
      end
      if (do_read) begin
        rd_ptr   <= rd_ptr + LOG_DEPTH'(1);
        out_data <= mem[rd_ptr];
      end
      out_nd <= do_read;
      if (do_write && !do_read) begin
        fill <= fill + (LOG_DEPTH + 1)'(1);
      end else if (!do_write && do_read) begin
        fill <= fill - (LOG_DEPTH + 1)'(1);
      end
    end
  end

  // Storage array; contents need no reset since fill gates every read.
  always_ff @(posedge clk) begin
    if (!reset && do_write) begin
      mem[wr_ptr] <= in_data;
    end
  end

`ifdef QA_LOOPBACK_OVERFLOW_ERR_EN
  // Sticky overflow flag: any valid word that was not stored is a drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      error <= 1'b0;
    end else if (in_nd && !do_write) begin
      error <= 1'b1;
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_qa_buffer_loopback.sv
// ---------------------------------------------------------------------------
// tb_qa_buffer_loopback
//
// Bench for qa_buffer_loopback. Three instances share clk/reset/in_*:
//   dut_a : LOG_DEPTH=2,  GAP=0
//   dut_b : LOG_DEPTH=4,  GAP=3
//   dut_c : LOG_DEPTH=2,  GAP=7
// Each test targets one instance. A scoreboard queue holds words accepted by
// the reference model; the model decides when a word leaves (cool-down count
// since the last departure) and pops the expected word at that point.
// ---------------------------------------------------------------------------
module tb_qa_buffer_loopback;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_nd;
  logic [31:0] in_data;

  logic [31:0] data_a, data_b, data_c;
  logic        nd_a, nd_b, nd_c;
  logic        err_a, err_b, err_c;
  logic [2:0]  fill_a;
  logic [4:0]  fill_b;
  logic [2:0]  fill_c;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] sb [$];
  int          cool;
  logic        exp_nd;
  logic [31:0] exp_data;
  int          exp_fill;
  logic        exp_err;
  int          drops;
  int          cyc;

  // Observed outputs of the targeted instance after the last edge
  logic        obs_nd;
  logic [31:0] obs_data;
  int          obs_fill;
  logic        obs_err;

  always #5 clk = ~clk;

  qa_buffer_loopback #(.WDTH(32), .LOG_DEPTH(2), .GAP(0)) dut_a (
    .clk(clk), .reset(reset), .in_data(in_data), .in_nd(in_nd),
    .out_data(data_a), .out_nd(nd_a), .error(err_a), .fill(fill_a));

  qa_buffer_loopback #(.WDTH(32), .LOG_DEPTH(4), .GAP(3)) dut_b (
    .clk(clk), .reset(reset), .in_data(in_data), .in_nd(in_nd),
    .out_data(data_b), .out_nd(nd_b), .error(err_b), .fill(fill_b));

  qa_buffer_loopback #(.WDTH(32), .LOG_DEPTH(2), .GAP(7)) dut_c (
    .clk(clk), .reset(reset), .in_data(in_data), .in_nd(in_nd),
    .out_data(data_c), .out_nd(nd_c), .error(err_c), .fill(fill_c));

  // Drive one cycle of stimulus, advance the model over the coming edge,
  // then sample the targeted instance 1 time unit after that edge.
  task automatic tick(input int inst, input logic rst, input logic nd,
                      input logic [31:0] d);
    int depth;
    int gap;
    bit rd;
    bit wr;
    depth = (inst == 1) ? 16 : 4;
    gap   = (inst == 0) ? 0 : ((inst == 1) ? 3 : 7);
    reset   = rst;
    in_nd   = nd;
    in_data = d;
    if (rst) begin
      sb.delete();
      cool     = 0;
      exp_nd   = 1'b0;
      exp_data = 32'd0;
      exp_err  = 1'b0;
    end else begin
      rd = (cool == 0) && (sb.size() > 0);
      wr = nd && ((sb.size() < depth) || rd);
      exp_nd = rd;
      if (rd) begin
        exp_data = sb.pop_front();
        cool     = gap;
      end else if (cool > 0) begin
        cool--;
      end
      if (wr) sb.push_back(d);
      if (nd && !wr) begin
        drops++;
`ifdef QA_LOOPBACK_OVERFLOW_ERR_EN
        exp_err = 1'b1;
`endif
      end
    end
    exp_fill = sb.size();
    @(posedge clk);
    #1;
    cyc++;
    case (inst)
      0: begin obs_nd = nd_a; obs_data = data_a; obs_fill = int'(fill_a); obs_err = err_a; end
      1: begin obs_nd = nd_b; obs_data = data_b; obs_fill = int'(fill_b); obs_err = err_b; end
      default: begin obs_nd = nd_c; obs_data = data_c; obs_fill = int'(fill_c); obs_err = err_c; end
    endcase
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(0, 1'b1, 1'b1, 32'h1234_5678);
    for (int i = 0; i < 10; i++) begin
      tick(0, 1'b0, 1'b0, 32'd0);
      checks++; if (obs_nd !== 1'b0) begin errors++; $display("[TB] FAIL reset_nd cyc=%0d got=%0b exp=0", cyc, obs_nd); end
      checks++; if (obs_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_data cyc=%0d got=%h exp=0", cyc, obs_data); end
      checks++; if (obs_fill !== 0) begin errors++; $display("[TB] FAIL reset_fill cyc=%0d got=%0d exp=0", cyc, obs_fill); end
      checks++; if (obs_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err cyc=%0d got=%0b exp=0", cyc, obs_err); end
    end
    checks++; if ({nd_b, nd_c, err_b, err_c} !== 4'b0) begin errors++; $display("[TB] FAIL reset_others got=%b exp=0000", {nd_b, nd_c, err_b, err_c}); end
    checks++; if ({fill_b, fill_c} !== 8'd0) begin errors++; $display("[TB] FAIL reset_other_fill got=%h exp=00", {fill_b, fill_c}); end
  endtask

  task automatic test_single_latency();
    logic exp_k_nd;
    tick(0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) tick(0, 1'b0, 1'b0, 32'd0);
    tick(0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    // Cycle right after the write: word stored, not yet emitted.
    checks++; if (obs_fill !== 1) begin errors++; $display("[TB] FAIL latency_fill1 got=%0d exp=1", obs_fill); end
    checks++; if (obs_nd !== 1'b0) begin errors++; $display("[TB] FAIL latency_early_nd got=%0b exp=0", obs_nd); end
    for (int k = 2; k <= 8; k++) begin
      tick(0, 1'b0, 1'b0, 32'd0);
      exp_k_nd = (k == 2);
      checks++; if (obs_nd !== exp_k_nd) begin errors++; $display("[TB] FAIL latency_nd k=%0d got=%0b exp=%0b", k, obs_nd, exp_k_nd); end
      checks++; if (obs_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL latency_data k=%0d got=%h exp=deadbeef", k, obs_data); end
      checks++; if (obs_fill !== 0) begin errors++; $display("[TB] FAIL latency_fill0 k=%0d got=%0d exp=0", k, obs_fill); end
    end
  endtask

  task automatic test_throttled_burst();
    int n_out;
    int obs_peak;
    int exp_peak;
    n_out = 0; obs_peak = 0; exp_peak = 0;
    tick(1, 1'b1, 1'b0, 32'd0);
    for (int j = 0; j < 48; j++) begin
      if (j < 8) tick(1, 1'b0, 1'b1, 32'(j + 1));
      else       tick(1, 1'b0, 1'b0, 32'd0);
      if (obs_fill > obs_peak) obs_peak = obs_fill;
      if (exp_fill > exp_peak) exp_peak = exp_fill;
      checks++; if (obs_nd !== exp_nd) begin errors++; $display("[TB] FAIL burst_nd j=%0d got=%0b exp=%0b", j, obs_nd, exp_nd); end
      checks++; if (obs_data !== exp_data) begin errors++; $display("[TB] FAIL burst_data j=%0d got=%h exp=%h", j, obs_data, exp_data); end
      checks++; if (obs_fill !== exp_fill) begin errors++; $display("[TB] FAIL burst_fill j=%0d got=%0d exp=%0d", j, obs_fill, exp_fill); end
      if (obs_nd === 1'b1) begin
        // Word k (0-based) must leave at cycle t+2+4k, i.e. after tick j=1+4k.
        checks++; if (j !== 1 + 4 * n_out) begin errors++; $display("[TB] FAIL burst_spacing word=%0d got_j=%0d exp_j=%0d", n_out, j, 1 + 4 * n_out); end
        n_out++;
      end
    end
    checks++; if (n_out !== 8) begin errors++; $display("[TB] FAIL burst_count got=%0d exp=8", n_out); end
    checks++; if (obs_peak !== exp_peak) begin errors++; $display("[TB] FAIL burst_peak got=%0d exp=%0d", obs_peak, exp_peak); end
  endtask

  task automatic test_overflow();
    int n_out;
    int n_acc;
    n_out = 0;
    tick(2, 1'b1, 1'b0, 32'd0);
    drops = 0;
    for (int j = 0; j < 80; j++) begin
      if (j < 10) tick(2, 1'b0, 1'b1, 32'(j));
      else        tick(2, 1'b0, 1'b0, 32'd0);
      if (j == 9) n_acc = 10 - drops;
      if (obs_nd === 1'b1) n_out++;
      checks++; if (obs_nd !== exp_nd) begin errors++; $display("[TB] FAIL ovf_nd j=%0d got=%0b exp=%0b", j, obs_nd, exp_nd); end
      checks++; if (obs_data !== exp_data) begin errors++; $display("[TB] FAIL ovf_data j=%0d got=%h exp=%h", j, obs_data, exp_data); end
      checks++; if (obs_fill !== exp_fill) begin errors++; $display("[TB] FAIL ovf_fill j=%0d got=%0d exp=%0d", j, obs_fill, exp_fill); end
      checks++; if (obs_err !== exp_err) begin errors++; $display("[TB] FAIL ovf_err j=%0d got=%0b exp=%0b", j, obs_err, exp_err); end
    end
    checks++; if (n_out !== n_acc) begin errors++; $display("[TB] FAIL ovf_count got=%0d exp=%0d", n_out, n_acc); end
  endtask

  task automatic test_full_boundary();
    int n_out;
    n_out = 0;
    tick(0, 1'b1, 1'b0, 32'd0);
    for (int j = 0; j < 30; j++) begin
      if (j < 20) tick(0, 1'b0, 1'b1, 32'(100 + j));
      else        tick(0, 1'b0, 1'b0, 32'd0);
      if (obs_nd === 1'b1) n_out++;
      if (j < 20) begin
        checks++; if (obs_fill !== 1) begin errors++; $display("[TB] FAIL full_fill j=%0d got=%0d exp=1", j, obs_fill); end
      end
      checks++; if (obs_nd !== exp_nd) begin errors++; $display("[TB] FAIL full_nd j=%0d got=%0b exp=%0b", j, obs_nd, exp_nd); end
      checks++; if (obs_data !== exp_data) begin errors++; $display("[TB] FAIL full_data j=%0d got=%h exp=%h", j, obs_data, exp_data); end
      checks++; if (obs_err !== 1'b0) begin errors++; $display("[TB] FAIL full_err j=%0d got=%0b exp=0", j, obs_err); end
    end
    checks++; if (n_out !== 20) begin errors++; $display("[TB] FAIL full_count got=%0d exp=20", n_out); end
  endtask

  task automatic test_reset_mid_burst();
    tick(2, 1'b1, 1'b0, 32'd0);
    for (int j = 0; j < 4; j++) tick(2, 1'b0, 1'b1, 32'h10 + 32'(j));
    checks++; if (obs_fill !== 3) begin errors++; $display("[TB] FAIL midrst_prefill got=%0d exp=3", obs_fill); end
    // in_nd during the reset cycle must be ignored.
    tick(2, 1'b1, 1'b1, 32'h99);
    checks++; if (obs_nd !== 1'b0) begin errors++; $display("[TB] FAIL midrst_nd got=%0b exp=0", obs_nd); end
    checks++; if (obs_fill !== 0) begin errors++; $display("[TB] FAIL midrst_fill got=%0d exp=0", obs_fill); end
    tick(2, 1'b0, 1'b1, 32'hA5);
    checks++; if (obs_nd !== 1'b0 || obs_fill !== 1) begin errors++; $display("[TB] FAIL midrst_store got nd=%0b fill=%0d exp nd=0 fill=1", obs_nd, obs_fill); end
    tick(2, 1'b0, 1'b0, 32'd0);
    checks++; if (obs_nd !== 1'b1 || obs_data !== 32'hA5) begin errors++; $display("[TB] FAIL midrst_out got nd=%0b data=%h exp nd=1 data=a5", obs_nd, obs_data); end
    for (int j = 0; j < 20; j++) begin
      tick(2, 1'b0, 1'b0, 32'd0);
      checks++; if (obs_nd !== exp_nd || obs_data !== exp_data) begin errors++; $display("[TB] FAIL midrst_stale j=%0d got nd=%0b data=%h exp nd=%0b data=%h", j, obs_nd, obs_data, exp_nd, exp_data); end
    end
  endtask

  task automatic test_random(input int inst);
    logic nd;
    tick(inst, 1'b1, 1'b0, 32'd0);
    for (int j = 0; j < 150; j++) begin
      nd = 1'($urandom_range(0, 1));
      tick(inst, 1'b0, nd, $urandom);
      checks++; if (obs_nd !== exp_nd) begin errors++; $display("[TB] FAIL rand%0d_nd j=%0d got=%0b exp=%0b", inst, j, obs_nd, exp_nd); end
      checks++; if (obs_data !== exp_data) begin errors++; $display("[TB] FAIL rand%0d_data j=%0d got=%h exp=%h", inst, j, obs_data, exp_data); end
      checks++; if (obs_fill !== exp_fill) begin errors++; $display("[TB] FAIL rand%0d_fill j=%0d got=%0d exp=%0d", inst, j, obs_fill, exp_fill); end
      checks++; if (obs_err !== exp_err) begin errors++; $display("[TB] FAIL rand%0d_err j=%0d got=%0b exp=%0b", inst, j, obs_err, exp_err); end
    end
  endtask

  initial begin
    reset = 1'b1; in_nd = 1'b0; in_data = 32'd0;
    cool = 0; exp_nd = 1'b0; exp_data = 32'd0; exp_fill = 0; exp_err = 1'b0;
    drops = 0; cyc = 0;
    test_reset();
    test_single_latency();
    test_throttled_burst();
    test_overflow();
    test_full_boundary();
    test_reset_mid_burst();
    test_random(0);
    test_random(1);
    test_random(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
